// File: rtl/tone_clk_pwm.sv
// Beat clock divider and square-wave tone generator for the music-box player.
// Define PWM_INVERT_EN to drive an active-low speaker (pwm_out idles high).
module tone_clk_pwm #(
  parameter int unsigned CLK_HZ   = 12000000,
  parameter int unsigned BEAT_HZ  = 4,
  parameter int unsigned PERIOD_W = 32
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                pwm_en,
  input  logic [PERIOD_W-1:0] freq,
  output logic                clk_out,
  output logic                pwm_out
);

  localparam int unsigned HALF_DIV = CLK_HZ / (2 * BEAT_HZ);
  localparam int unsigned DIV_W    = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_DIV - 1);

`ifdef PWM_INVERT_EN
  localparam logic PWM_INV = 1'b1;
`else
  localparam logic PWM_INV = 1'b0;
`endif

  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic                clk_out_q, clk_out_d;
  logic [PERIOD_W-1:0] tone_cnt_q, tone_cnt_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                pwm_q, pwm_d;

  always_comb begin
    div_cnt_d = div_cnt_q + DIV_W'(1);
    clk_out_d = clk_out_q;
    if (div_cnt_q == DIV_LAST) begin
      div_cnt_d = '0;
      clk_out_d = ~clk_out_q;
    end
  end

  // freq is only taken into period_q at a period boundary, so notes never glitch.
  always_comb begin
    tone_cnt_d = tone_cnt_q;
    period_d   = period_q;
    pwm_d      = PWM_INV;
    if (!pwm_en || (period_q == '0)) begin
      tone_cnt_d = '0;
      period_d   = freq;
    end else begin
      pwm_d = (tone_cnt_q < (period_q >> 1)) ^ PWM_INV;
      if (tone_cnt_q >= (period_q - PERIOD_W'(1))) begin
        tone_cnt_d = '0;
        period_d   = freq;
      end else begin
        tone_cnt_d = tone_cnt_q + PERIOD_W'(1);
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      div_cnt_q  <= '0;
      clk_out_q  <= 1'b0;
      tone_cnt_q <= '0;
      period_q   <= '0;
      pwm_q      <= PWM_INV;
    end else begin
      div_cnt_q  <= div_cnt_d;
      clk_out_q  <= clk_out_d;
      tone_cnt_q <= tone_cnt_d;
      period_q   <= period_d;
      pwm_q      <= pwm_d;
    end
  end

  assign clk_out = clk_out_q;
  assign pwm_out = pwm_q;

endmodule

// File: tb/tb_tone_clk_pwm.sv
// Self-checking bench for tone_clk_pwm: directed steps plus randomized tone traffic
// compared against a waveform-queue reference model.
module tb_tone_clk_pwm;

  localparam int CLK_HZ  = 16;
  localparam int BEAT_HZ = 2;
  localparam int PW      = 16;
  localparam int HALF    = CLK_HZ / (2 * BEAT_HZ);

`ifdef PWM_INVERT_EN
  localparam logic INV = 1'b1;
`else
  localparam logic INV = 1'b0;
`endif

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          pwm_en;
  logic [PW-1:0] freq;
  logic          clk_out;
  logic          pwm_out;

  int checks   = 0;
  int failures = 0;

  // Reference model: each tone period is expanded into its full high/low pattern.
  int   edges;
  bit   wave[$];
  int   armedP;
  logic expPwm;

  tone_clk_pwm #(
    .CLK_HZ  (CLK_HZ),
    .BEAT_HZ (BEAT_HZ),
    .PERIOD_W(PW)
  ) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .pwm_en (pwm_en),
    .freq   (freq),
    .clk_out(clk_out),
    .pwm_out(pwm_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic modelReset();
    edges  = 0;
    wave.delete();
    armedP = 0;
    expPwm = 1'b0;
  endtask

  task automatic modelEdge();
    edges++;
    if (!pwm_en) begin
      wave.delete();
      armedP = int'(freq);
      expPwm = 1'b0;
    end else begin
      if (wave.size() == 0 && armedP != 0) begin
        for (int i = 0; i < armedP; i++) wave.push_back(i < armedP / 2);
      end
      if (wave.size() == 0) begin
        expPwm = 1'b0;
        armedP = int'(freq);
      end else begin
        expPwm = wave.pop_front();
        if (wave.size() == 0) armedP = int'(freq);
      end
    end
  endtask

  task automatic checkOutput(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic en, input int f);
    pwm_en = en;
    freq   = PW'(f);
  endtask

  task automatic step();
    @(posedge clk_in);
    modelEdge();
    #1;
    checkOutput("clk_out", clk_out, ((edges / HALF) % 2) == 1);
    checkOutput("pwm_out", pwm_out, expPwm ^ INV);
  endtask

  initial begin
    bit   lit4[9];
    logic found;
    lit4 = '{0, 1, 1, 0, 0, 1, 1, 0, 0};

    rst_in = 1'b1;
    applyStimulus(1'b0, 0);
    #12;
    checkOutput("reset_clk_out", clk_out, 1'b0);
    checkOutput("reset_pwm_out", pwm_out, INV);
    @(negedge clk_in);
    rst_in = 1'b0;
    modelReset();

    applyStimulus(1'b1, 4);
    for (int i = 0; i < 9; i++) begin
      step();
      checkOutput("basic4_literal", pwm_out, lit4[i] ^ INV);
    end

    applyStimulus(1'b1, 5);
    for (int i = 0; i < 12; i++) step();

    applyStimulus(1'b1, 0);
    for (int i = 0; i < 8; i++) step();
    applyStimulus(1'b0, 6);
    for (int i = 0; i < 8; i++) step();

    applyStimulus(1'b1, 4);
    for (int i = 0; i < 6 && expPwm !== 1'b1; i++) step();
    applyStimulus(1'b0, 4);
    step();
    checkOutput("drop_mid_high", pwm_out, INV);

    applyStimulus(1'b1, 4);
    step();
    step();
    freq = PW'(8);
    for (int i = 0; i < 20; i++) step();

    applyStimulus(1'b1, 4);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (clk_out === 1'b1 && pwm_out === (1'b1 ^ INV)) found = 1'b1;
    end
    checkOutput("find_high_timeout", found, 1'b1);
    #3;
    rst_in = 1'b1;
    #1;
    checkOutput("async_clk_out", clk_out, 1'b0);
    checkOutput("async_pwm_out", pwm_out, INV);
    @(negedge clk_in);
    rst_in = 1'b0;
    modelReset();
    for (int i = 0; i < 12; i++) step();

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(5) == 0) freq = PW'($urandom_range(9));
      pwm_en = ($urandom_range(9) != 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tone_clk_pwm.md
Name: tone_clk_pwm

Overview:
- Timing/sound back end for the piano/music-box player.
- Derives a slow 50%-duty beat clock (default 4 Hz, one quarter-note step) from the system clock.
- Generates a square-wave tone whose period, in system-clock cycles, is supplied by the note lookup logic. freq = 0 means a rest (silence).
- Sits between the score sequencer (which consumes the beat clock and drives freq/pwm_en) and the speaker pin.

Parameters:
- CLK_HZ, 12000000, system clock frequency in Hz.
- BEAT_HZ, 4, beat clock output frequency in Hz.
- PERIOD_W, 32, width of the freq period input and the tone counter.
- Derived localparam HALF_DIV = CLK_HZ/(2*BEAT_HZ), default 1500000 cycles. Must be ≥1.

Ports:
- clk_in, input, 1, system clock; all logic on the rising edge.
- rst_in, input, 1, asynchronous active-high reset.
- pwm_en, input, 1, tone enable; 0 forces silence.
- freq, input, PERIOD_W, tone period in clk_in cycles (e.g. 45802 = 262 Hz at 12 MHz); 0 = rest.
- clk_out, output, 1, beat clock, 50% duty, registered.
- pwm_out, output, 1, speaker square wave, registered.

Behaviour:
- Reset (asynchronous, active-high): div_cnt = 0, clk_out = 0, tone_cnt = 0, latched period P = 0, pwm_out = 0.
- Beat divider, each cycle:
  - If div_cnt == HALF_DIV-1: div_cnt <= 0 and clk_out toggles.
  - Otherwise div_cnt increments.
  - First clk_out rise occurs HALF_DIV cycles after reset release; full period is 2*HALF_DIV cycles.
  - Runs free and is independent of pwm_en.
- Tone generator:
  - P is the internally latched period. freq is sampled only at period boundaries, so a note change never truncates or glitches a running cycle.
  - pwm_en = 0: tone_cnt <= 0, P <= freq, pwm_out <= 0.
  - pwm_en = 1 and P == 0 (rest): tone_cnt <= 0, P <= freq, pwm_out <= 0. A new nonzero freq is picked up on the next cycle.
  - pwm_en = 1 and P != 0:
    - pwm_out <= (tone_cnt < P>>1).
    - If tone_cnt ≥ P-1: tone_cnt <= 0 and P <= freq.
    - Otherwise tone_cnt increments.
  - Output period is exactly P cycles, high for floor(P/2) cycles, then low. P = 1 gives constant low.
  - Latency: pwm_out reflects tone_cnt one cycle later (registered).
- Enable drop mid-period:
  - Counter clears immediately.
  - pwm_out is 0 from the next edge.
  - On re-enable the tone restarts at phase 0 with the current freq.
- Width: tone_cnt and P are PERIOD_W bits. All comparisons are unsigned; there is no overflow since tone_cnt < P.
- Reset mid-operation returns every register to its reset value immediately (asynchronous).

Optional Feature:
- Macro PWM_INVERT_EN.
- Defined:
  - pwm_out is the logical inverse of the behaviour above, for an active-low speaker driver.
  - Reset, disabled and rest level is 1.
- Undefined: behaviour exactly as specified; idle level is 0.
- clk_out is unaffected either way.

Test Plan:
- Beat clock: CLK_HZ = 16, BEAT_HZ = 2 (HALF_DIV = 4); release reset → clk_out = 0 for 4 cycles, then high 4, low 4, repeating; period 8 cycles.
- Basic tone: pwm_en = 1, freq = 4 → after the one-cycle pickup and one-cycle output latency, pwm_out repeats 1,1,0,0; freq = 5 → 1,1,0,0,0.
- Rest and disable: freq = 0 with pwm_en = 1 → pwm_out stays 0. freq = 6 with pwm_en = 0 → pwm_out stays 0. Toggle pwm_en 1→0 mid-high → pwm_out is 0 on the next edge and tone_cnt = 0.
- Note change: freq changes 4→8 while tone_cnt = 1 → current period completes as 4 cycles; next period is 8 cycles (4 high, 4 low).
- Async reset: assert rst_in between clock edges while clk_out = 1 and pwm_out = 1 → both drop to 0 immediately; after release the beat restarts with a full HALF_DIV low phase.
- PWM_INVERT_EN defined, freq = 4 → pwm_out repeats 0,0,1,1; reset and disabled level is 1.
